// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle mult/multu/div/divu with HI/LO ownership.
// Optional signed floor divide (code 9) is built when MDU_FDIV_EN is defined.
module mdu #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_FDIV  = 4'd9
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

    state_e      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] hi_nxt, lo_nxt;
    logic        wr_pend;

    logic        is_mul, is_div, is_fdiv, is_sdiv, accept;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, q_t, r_t, q_f, r_f;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

`ifdef MDU_FDIV_EN
    assign is_fdiv = (MDUControl == OP_FDIV);
`else
    assign is_fdiv = 1'b0;
`endif

    assign is_mul = (MDUControl == OP_MULT) || (MDUControl == OP_MULTU);
    assign is_sdiv = (MDUControl == OP_DIV) || is_fdiv;
    assign is_div = is_sdiv || (MDUControl == OP_DIVU);
    assign accept = !reset && (state == S_IDLE) && (is_mul || is_div);
    assign Start  = accept;
    assign Busy   = (state == S_RUN);

    // Sign-extend to 64 bits so the signed product needs no signed-context tricks.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned magnitude divider serves every divide flavour; signs are
    // reapplied afterwards, which also makes 0x80000000 / -1 wrap cleanly.
    always_comb begin
        a_neg   = is_sdiv && A[31];
        b_neg   = is_sdiv && B[31];
        a_mag   = a_neg ? (32'd0 - A) : A;
        b_mag   = b_neg ? (32'd0 - B) : B;
        div_den = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / div_den;
        r_mag   = a_mag % div_den;
        q_t     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_t     = a_neg ? (32'd0 - r_mag) : r_mag;
        q_f     = q_t;
        r_f     = r_t;
`ifdef MDU_FDIV_EN
        // Floor correction: nonzero remainder with sign opposite the divisor.
        if (is_fdiv && (r_t != 32'd0) && (r_t[31] != B[31])) begin
            q_f = q_t - 32'd1;
            r_f = r_t + B;
        end
`endif
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b1;
        if (MDUControl == OP_MULT) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else if (MDUControl == OP_MULTU) begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
        end else if (is_div) begin
            res_hi = r_f;
            res_lo = q_f;
            res_wr = (B != 32'd0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN:  if (cnt == 8'd1) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi_nxt  <= '0;
            lo_nxt  <= '0;
            wr_pend <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                if (accept) begin
                    hi_nxt  <= res_hi;
                    lo_nxt  <= res_lo;
                    wr_pend <= res_wr;
                    cnt     <= is_mul ? MUL_CNT : DIV_CNT;
                end else if (MDUControl == OP_MTHI) begin
                    HI <= A;
                end else if (MDUControl == OP_MTLO) begin
                    LO <= A;
                end
            end else begin
                cnt <= cnt - 8'd1;
                if ((cnt == 8'd1) && wr_pend) begin
                    HI <= hi_nxt;
                    LO <= lo_nxt;
                end
            end
        end
    end

    always_comb begin
        MDUOut = '0;
        if (MDUControl == OP_MFHI)      MDUOut = HI;
        else if (MDUControl == OP_MFLO) MDUOut = LO;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu; exercises the fdiv path when MDU_FDIV_EN is defined.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUControl;
    logic [31:0] A, B;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDUOut;

    int n_checks = 0;
    int n_pass   = 0;

    mdu #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .MDUControl(MDUControl), .A(A), .B(B),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue an op from IDLE, then count Busy cycles until it drops.
    task automatic run_op(input string tag, input logic [3:0] code,
                          input logic [31:0] a, input logic [31:0] b, input int lat);
        int n;
        n = 0;
        MDUControl = code; A = a; B = b;
        #1 check({tag, " start"}, 32'(Start), 32'd1);
        step();
        MDUControl = 4'd0; A = '0; B = '0;
        while (Busy && n < 300) begin
            n++;
            step();
        end
        check({tag, " busy"}, 32'(n), 32'(lat));
    endtask

    initial begin
        int n;
        reset = 1'b1; MDUControl = 4'd0; A = '0; B = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst HI", HI, 32'h0);
        check("rst LO", LO, 32'h0);
        check("rst busy", 32'(Busy), 32'd0);

        run_op("mult", 4'd1, 32'hFFFFFFFF, 32'h2, 5);
        check("mult HI", HI, 32'hFFFFFFFF);
        check("mult LO", LO, 32'hFFFFFFFE);

        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'h2, 5);
        check("multu HI", HI, 32'h1);
        check("multu LO", LO, 32'hFFFFFFFE);

        run_op("div", 4'd3, 32'hFFFFFFF9, 32'h2, 10);
        check("div LO", LO, 32'hFFFFFFFD);
        check("div HI", HI, 32'hFFFFFFFF);

        MDUControl = 4'd7; A = 32'h11;
        #1 check("mthi start", 32'(Start), 32'd0);
        step();
        MDUControl = 4'd8; A = 32'h22;
        step();
        MDUControl = 4'd0; A = '0;
        #1;
        check("mthi HI", HI, 32'h11);
        check("mtlo LO", LO, 32'h22);
        check("mtx busy", 32'(Busy), 32'd0);

        run_op("divu0", 4'd4, 32'h7, 32'h0, 10);
        check("divu0 HI", HI, 32'h11);
        check("divu0 LO", LO, 32'h22);

        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        check("divovf LO", LO, 32'h80000000);
        check("divovf HI", HI, 32'h0);

        // Writes and new ops while busy must be dropped.
        MDUControl = 4'd2; A = 32'h00010001; B = 32'h00010000;
        #1 check("blk start", 32'(Start), 32'd1);
        step();
        MDUControl = 4'd7; A = 32'hDEAD;
        #1 check("blk mthi start", 32'(Start), 32'd0);
        check("blk busy", 32'(Busy), 32'd1);
        step();
        MDUControl = 4'd1; A = 32'h5; B = 32'h5;
        #1 check("blk mult start", 32'(Start), 32'd0);
        step();
        MDUControl = 4'd0; A = '0; B = '0;
        #1;
        check("blk HI hold", HI, 32'h0);
        n = 2;
        while (Busy && n < 300) begin
            n++;
            step();
        end
        check("blk busy len", 32'(n), 32'd5);
        check("blk HI", HI, 32'h1);
        check("blk LO", LO, 32'h00010000);
        MDUControl = 4'd5;
        #1 check("mfhi", MDUOut, 32'h1);
        MDUControl = 4'd6;
        #1 check("mflo", MDUOut, 32'h00010000);
        MDUControl = 4'd0;
        #1 check("mdu none out", MDUOut, 32'h0);

        MDUControl = 4'd12; A = 32'h1234; B = 32'h5;
        #1;
        check("rsv start", 32'(Start), 32'd0);
        check("rsv out", MDUOut, 32'h0);
        step();
        MDUControl = 4'd0;
        #1;
        check("rsv busy", 32'(Busy), 32'd0);
        check("rsv HI", HI, 32'h1);

`ifdef MDU_FDIV_EN
        run_op("fdiv", 4'd9, 32'hFFFFFFF9, 32'h2, 10);
        check("fdiv LO", LO, 32'hFFFFFFFC);
        check("fdiv HI", HI, 32'h00000001);
`else
        MDUControl = 4'd9; A = 32'hFFFFFFF9; B = 32'h2;
        #1 check("fdiv off start", 32'(Start), 32'd0);
        step();
        MDUControl = 4'd0;
        #1 check("fdiv off busy", 32'(Busy), 32'd0);
`endif

        // Reset on the 4th Busy cycle of a divu.
        MDUControl = 4'd4; A = 32'd100; B = 32'd3;
        #1 check("rstmid start", 32'(Start), 32'd1);
        step();
        MDUControl = 4'd0;
        step(); step(); step();
        check("rstmid busy4", 32'(Busy), 32'd1);
        reset = 1'b1; MDUControl = 4'd1;
        #1 check("rst start", 32'(Start), 32'd0);
        step();
        reset = 1'b0; MDUControl = 4'd0;
        #1;
        check("rstmid busy", 32'(Busy), 32'd0);
        check("rstmid HI", HI, 32'h0);
        check("rstmid LO", LO, 32'h0);

        run_op("mult2", 4'd1, 32'hFFFFFFFD, 32'h4, 5);
        check("mult2 HI", HI, 32'hFFFFFFFF);
        check("mult2 LO", LO, 32'hFFFFFFF4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage. It is the consumer of the 4-bit MDUControl code the decoder emits.
- Executes mult/multu/div/divu with fixed multi-cycle latency and owns the HI/LO registers.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Exposes Start/Busy so the hazard unit can stall the D stage on MDU-dependent instructions.

Parameters:
- MUL_LAT, 5, Busy cycles for mult/multu (legal range 1..255).
- DIV_LAT, 10, Busy cycles for div/divu/fdiv (legal range 1..255).

Ports:
- clk  input  1  Single clock; all state updates on posedge.
- reset  input  1  Synchronous, active-high reset.
- MDUControl  input  4  Operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 fdiv; 10-15 reserved (no-op).
- A  input  32  rs operand (forwarded value).
- B  input  32  rt operand (forwarded value).
- Start  output  1  Combinational; high when a mult/div class op is accepted this cycle.
- Busy  output  1  Registered; high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MDUOut  output  32  Combinational read data: HI when code=5, LO when code=6, else 0.

Behaviour:
- Reset: on a posedge with reset=1:
  - HI=0, LO=0, Busy=0, counter=0.
  - Any pending result is discarded, including mid-operation.
  - Start is 0 during reset.
- States: IDLE (Busy=0) and RUN (Busy=1). An 8-bit down-counter cnt plus result registers hi_nxt/lo_nxt.
- Accept: in IDLE, when code ∈ {1,2,3,4} (plus 9 if enabled):
  - Start=1 for that cycle.
  - Full result is computed from A/B and latched into hi_nxt/lo_nxt at the edge.
  - cnt is loaded with MUL_LAT or DIV_LAT; next state is RUN.
- RUN: cnt decrements each edge. On the edge where cnt==1, HI/LO are loaded from hi_nxt/lo_nxt, Busy→0 and state→IDLE.
- Timing: op accepted in cycle T gives Busy=1 in cycles T+1..T+LAT. HI/LO hold new values from cycle T+LAT+1.
- Ops while Busy: every code, including mult/div/mthi/mtlo, is ignored and Start=0. The hazard unit guarantees stall; the MDU does not queue.
- mthi/mtlo in IDLE: HI←A (code 7) or LO←A (code 8) at the next edge. No Busy.
- mfhi/mflo: MDUOut reflects current HI/LO combinationally, no latency. Valid only when Busy=0.
- mult: signed 32x32→64. multu: unsigned. In both, HI=product[63:32] and LO=product[31:0].
- div/divu (signed/unsigned, truncate toward zero):
  - LO=quotient, HI=remainder; remainder sign follows the dividend.
- Divide by zero (B=0): operation is accepted and Busy runs the full DIV_LAT, but HI/LO are left unchanged at completion.
- Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No exception.
- Reserved codes 10-15: no state change, Start=0, MDUOut=0.

Optional Feature:
- Macro: MDU_FDIV_EN
- Defined: code 9 = signed floor division.
  - Quotient rounds toward −∞ and is placed in LO.
  - Remainder goes to HI and has the sign of the divisor (zero remainder stays 0).
  - Uses DIV_LAT; B=0 leaves HI/LO unchanged.
- Undefined: code 9 is treated as reserved (no-op, Start=0). The fdiv datapath is not synthesized.

Test Plan:
- Signed mult: reset; code=1, A=0xFFFFFFFF, B=0x00000002 → Start=1 in the issue cycle, Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu and signed div:
  - code=2 with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
  - code=3, A=0xFFFFFFF9 (−7), B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Edge cases:
  - divu A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo → Busy lasts 10 cycles; HI=0x11, LO=0x22 afterwards.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Busy blocking: during Busy, apply code=7 with A=0xDEAD and code=1 → both ignored, Start=0, HI unchanged. Then code=5 after Busy falls → MDUOut equals the completed HI.
- Reset mid-operation: code=4, A=100, B=3; assert reset on the 4th Busy cycle → next cycle Busy=0, HI=0, LO=0. A new mult issued afterwards completes normally.
- With MDU_FDIV_EN: code=9, A=−7, B=2 → LO=0xFFFFFFFC, HI=0x00000001. Without the macro: code=9 → Start=0, Busy stays 0.
